// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain
//   Read-side adapter for fifo_sync. Turns the FIFO's rd_en / registered
//   rd_data handshake (data returns one cycle after rd_en) into a
//   first-word-fall-through valid/ready stream. A 2-entry output buffer plus
//   a one-bit in-flight credit keeps full throughput while never committing
//   more than two words (buffered + in flight).
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous reset, active-high
//   fifo_empty    upstream FIFO empty flag
//   fifo_rd_en    pop request to FIFO (combinational from registered state,
//                 fifo_empty and m_ready)
//   fifo_rd_data  FIFO read data, valid one cycle after fifo_rd_en
//   m_valid       output word available
//   m_ready       consumer accepts; transfer = m_valid && m_ready
//   m_data        head of buffer
//   level         words held in the buffer (0..2)
//   stall_cnt     (only with DRAIN_STALL_CNT_EN) saturating count of cycles
//                 with m_valid && !m_ready
//
// Build option
//   DRAIN_STALL_CNT_EN  adds the stall_cnt output and its counter.
//
// Buffer states
//   state    | meaning
//   ST_EMPTY | no words buffered, m_valid low
//   ST_ONE   | head holds one word
//   ST_TWO   | head and tail both hold words, tail is younger

module fifo_stream_drain #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       level
`ifdef DRAIN_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [WIDTH-1:0] w_head_nxt;
    logic [WIDTH-1:0] w_tail_nxt;
    logic [1:0]       w_level_nxt;
    logic             r_inflight;
    logic             r_valid;
    logic [1:0]       r_level;
    logic             w_pop;
    logic             w_capture;
    logic [2:0]       w_committed;

    assign w_pop       = r_valid && m_ready;
    assign w_capture   = r_inflight;
    assign w_committed = {1'b0, r_level} + {2'b00, r_inflight};

    // Words buffered plus in flight, less the one leaving this cycle, must
    // stay below 2 for another read to be issued.
    assign fifo_rd_en = !rst && !fifo_empty
                        && (w_committed < (3'd2 + {2'b00, w_pop}));

    assign m_valid = r_valid;
    assign m_data  = r_head;
    assign level   = r_level;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_level_nxt = r_level;
        case (r_state)
            ST_EMPTY: begin
                if (w_capture) begin
                    w_head_nxt  = fifo_rd_data;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_capture && !w_pop) begin
                    w_tail_nxt  = fifo_rd_data;
                    w_state_nxt = ST_TWO;
                end else if (w_capture && w_pop) begin
                    w_head_nxt  = fifo_rd_data;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // capture without pop is unreachable: the issue rule never
                // lets a third word be in flight while two are buffered.
                if (w_pop) begin
                    w_head_nxt = r_tail;
                    if (w_capture) begin
                        w_tail_nxt = fifo_rd_data;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        case (w_state_nxt)
            ST_ONE:  w_level_nxt = 2'd1;
            ST_TWO:  w_level_nxt = 2'd2;
            default: w_level_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_head     <= '0;
            r_tail     <= '0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_level    <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_inflight <= fifo_rd_en;
            r_valid    <= (w_state_nxt != ST_EMPTY);
            r_level    <= w_level_nxt;
        end
    end

`ifdef DRAIN_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (r_valid && !m_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Downstream read-side adapter for the synchronous FIFO.
- Converts the FIFO's rd_en / registered rd_data interface (data one cycle after rd_en) into a first-word-fall-through valid/ready output stream.
- Runs at full throughput using a 2-entry output buffer and read-issue credit tracking.
- Sits between fifo_sync and any valid/ready consumer, in the same clock domain.

Parameters:
- WIDTH, 8, data width; must match the upstream FIFO WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_rd_en  output  1  pop request to FIFO; data returns on fifo_rd_data the next cycle.
- fifo_rd_data  input  WIDTH  FIFO read data; valid exactly one cycle after fifo_rd_en=1.
- m_valid  output  1  output word available.
- m_ready  input  1  consumer accepts; transfer = m_valid && m_ready.
- m_data  output  WIDTH  output word (head of buffer).
- level  output  2  words held in buffer (0..2).

Behaviour:
- Reset: rst sampled at posedge clk.
  - Reset values: m_valid=0, m_data=0, level=0, fifo_rd_en=0, buffer state EMPTY, inflight=0.
  - A read in flight when rst asserts is discarded; its returning data is never captured. The upstream FIFO is reset by the same rst.
- Buffer FSM states: EMPTY (level 0), ONE (level 1), TWO (level 2). m_valid = (state != EMPTY); m_data = head entry. All outputs are registered except fifo_rd_en, which is combinational from registered state, fifo_empty and m_ready.
- inflight: 1-bit register, equal to the previous cycle's fifo_rd_en.
- pop = m_valid && m_ready.
- Issue rule: fifo_rd_en = !rst && !fifo_empty && (level + inflight - pop < 2). Never more than 2 words committed (buffered plus in flight).
- Capture: when inflight=1, fifo_rd_data is written into the buffer at the end of that cycle.
  - If the buffer is EMPTY, or ONE with a simultaneous pop, the word becomes head or tail in FIFO order.
  - Ordering is strictly preserved.
- Transitions, keyed on (capture, pop):
  - EMPTY: capture -> ONE; otherwise stay.
  - ONE: capture && !pop -> TWO; !capture && pop -> EMPTY; otherwise stay (on capture && pop the new word becomes head).
  - TWO: pop && !capture -> ONE (tail moves to head); pop && capture -> TWO (tail to head, new word to tail); !pop -> stay. capture && !pop in TWO cannot happen by construction; verification asserts it.
- Latency: fifo_empty falls in cycle N -> fifo_rd_en=1 in cycle N -> m_valid=1 from cycle N+2.
- Throughput: with fifo_empty=0 and m_ready=1 held, one word per cycle after the initial 2-cycle fill.
- Backpressure: with m_ready=0, at most 2 words are popped from the FIFO, then fifo_rd_en stays 0.
- m_data and m_valid are stable while m_valid && !m_ready.
- fifo_rd_en is never asserted while fifo_empty=1 (satisfies the FIFO's read-side contract).

Optional Feature:
- Macro: DRAIN_STALL_CNT_EN.
- Defined:
  - Extra output port stall_cnt, 16 bits.
  - Reset to 0 by rst.
  - Increments every cycle m_valid && !m_ready; saturates at 16'hFFFF.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with fifo_empty=1 -> m_valid=0, level=0, fifo_rd_en=0 throughout.
- Single word: FIFO holds 8'hA5, m_ready=1 -> fifo_rd_en pulses for 1 cycle; m_valid=1 with m_data=8'hA5 exactly 2 cycles later for 1 cycle; level returns to 0.
- Streaming: 16 words 0x00..0x0F in FIFO, m_ready=1 -> outputs 0x00..0x0F on 16 consecutive cycles, in order, no gaps after first.
- Backpressure: 4 words queued, m_ready=0 for 10 cycles -> exactly 2 fifo_rd_en pulses, level=2, m_data=first word stable; then m_ready=1 -> remaining words follow in order, no loss or duplication.
- Reset mid-flight: rst asserted in the cycle after fifo_rd_en=1 -> next cycle m_valid=0, level=0; the returning word is not presented.
- DRAIN_STALL_CNT_EN defined: 1 word buffered, m_ready=0 for 5 cycles -> stall_cnt=5; forcing 70000 stall cycles -> stall_cnt=16'hFFFF.
